button_press_decoder: RTL

Conditions a raw, asynchronous push-button contact into clean, single-cycle event strobes for the LED control logic. It synchronises the pin, debounces it with a cycle-counted stability window, and emits press, release and optional long-press pulses. It sits between the board button pin and the `push_button` input of `led_ctrl`; `press_pulse` drives that input directly.

---
 rtl/button_press_decoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/button_press_decoder.sv
`default_nettype none
// ============================================================================
// button_press_decoder: synchronises and debounces a raw push-button and emits
// one-cycle press / release / long-press strobes.
// Optional long press: define BTN_LONG_PRESS_EN.
// Revision: 1.0
// ============================================================================
module button_press_decoder #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      sync_q;
    logic            btn_s;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], button_raw};
        end
    end

    assign btn_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            button_level  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state        <= HELD;
                        press_pulse  <= 1'b1;
                        button_level <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        button_level  <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int               HOLD_W    = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              long_flag;
    logic              release_now;

    // Suppress a long press on the very edge a release completes.
    assign release_now = (state == RELEASE_WAIT) && !btn_s && (db_cnt == DB_LAST);

    // Hold time keeps running through release bounces so the long press
    // stays exactly LONG_PRESS_CYCLES after the press strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt         <= '0;
            long_flag        <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            long_press_pulse <= 1'b0;
            if (state == PRESS_WAIT) begin
                hold_cnt  <= '0;
                long_flag <= 1'b0;
            end else if (state == HELD || state == RELEASE_WAIT) begin
                if (hold_cnt != HOLD_LAST) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                if (hold_cnt == HOLD_LAST && !long_flag && !release_now) begin
                    long_press_pulse <= 1'b1;
                    long_flag        <= 1'b1;
                end
            end
        end
    end
`else
    assign long_press_pulse = 1'b0;
`endif

endmodule
`default_nettype wire
